// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds it for WAIT_CYCLES
// wait states, then returns a one-cycle response with read data or a write acknowledge.
//
// state  | meaning
// S_IDLE | ready for a request; no access outstanding
// S_WAIT | request captured; counting down wait states
// S_RESP | response strobe cycle; back to S_IDLE next
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk_87,
    input  logic                    rst_87,
    input  logic                    req_valid_87,
    input  logic                    req_wr_87,
    input  logic [ADDR_WIDTH-1:0]   req_addr_87,
    input  logic [DATA_WIDTH-1:0]   req_wdata_87,
    input  logic [DATA_WIDTH/8-1:0] req_be_87,
    output logic                    req_ready_87,
    output logic                    rsp_valid_87,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_87,
    output logic                    rsp_err_87,
    output logic                    stall_87
);

    localparam int         BE_W     = DATA_WIDTH / 8;
    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam int         INIT_INT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_INIT = 4'(INIT_INT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;
    logic                    in_err, cur_err;
    logic [DEPTH_LOG2-1:0]   in_idx, cur_idx;
    logic                    cur_wr;
    logic                    enter_resp;
    logic                    err_q, wr_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign accept  = req_valid_87 && (state_q == S_IDLE);
    assign in_err  = (req_addr_87[1:0] != 2'b00) ||
                     (req_addr_87[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);
    assign in_idx  = req_addr_87[DEPTH_LOG2+1:2];

    // With zero wait states RESP is entered on the accept edge, before the capture regs load.
    assign cur_err = (state_q == S_IDLE) ? in_err    : err_q;
    assign cur_idx = (state_q == S_IDLE) ? in_idx    : idx_q;
    assign cur_wr  = (state_q == S_IDLE) ? req_wr_87 : wr_q;
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_87 = (state_q == S_IDLE);
        rsp_valid_87 = (state_q == S_RESP);
        stall_87     = (state_q != S_IDLE);
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            err_q        <= 1'b0;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            rsp_rdata_87 <= '0;
            rsp_err_87   <= 1'b0;
        end else begin
            if (accept) begin
                err_q <= in_err;
                wr_q  <= req_wr_87;
                idx_q <= in_idx;
            end
            if (enter_resp) begin
                rsp_err_87   <= cur_err;
                rsp_rdata_87 <= (cur_err || cur_wr) ? '0 : mem[cur_idx];
            end
        end
    end

    // Stores commit on the accept edge; the array is deliberately not reset.
    always_ff @(posedge clk_87) begin
        if (!rst_87 && accept && req_wr_87 && !in_err) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be_87[b]) mem[in_idx][b*8 +: 8] <= req_wdata_87[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        clk_87 = 1'b0;
    logic        rst_87;

    logic        a_valid, a_wr, a_ready, a_rsp_valid, a_err, a_stall;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;

    logic        b_valid, b_wr, b_ready, b_rsp_valid, b_err, b_stall;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_87 = ~clk_87;

    dmem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
        .clk_87(clk_87), .rst_87(rst_87),
        .req_valid_87(a_valid), .req_wr_87(a_wr), .req_addr_87(a_addr),
        .req_wdata_87(a_wdata), .req_be_87(a_be), .req_ready_87(a_ready),
        .rsp_valid_87(a_rsp_valid), .rsp_rdata_87(a_rdata), .rsp_err_87(a_err),
        .stall_87(a_stall)
    );

    dmem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk_87(clk_87), .rst_87(rst_87),
        .req_valid_87(b_valid), .req_wr_87(b_wr), .req_addr_87(b_addr),
        .req_wdata_87(b_wdata), .req_be_87(b_be), .req_ready_87(b_ready),
        .rsp_valid_87(b_rsp_valid), .rsp_rdata_87(b_rdata), .rsp_err_87(b_err),
        .stall_87(b_stall)
    );

    task automatic tick;
        @(posedge clk_87);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called right after the accept edge; counts edges until the response strobe.
    task automatic wait_rsp(output int lat, output int stall_cnt);
        lat       = 1;
        stall_cnt = int'(a_stall);
        while (!a_rsp_valid && lat < 12) begin
            tick;
            lat++;
            stall_cnt += int'(a_stall);
        end
    endtask

    task automatic a_access(input string name, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] exp_rdata, input logic exp_err);
        int lat, st;
        a_valid = 1'b1; a_wr = wr; a_addr = addr; a_wdata = wdata; a_be = be;
        check({name, ".ready_idle"}, 32'(a_ready), 32'd1);
        tick;
        // scramble inputs after acceptance; the captured request must be used
        a_valid = 1'b0; a_wr = ~wr; a_addr = 32'h0000_0024; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF;
        check({name, ".ready_drop"}, 32'(a_ready), 32'd0);
        wait_rsp(lat, st);
        check({name, ".latency"}, 32'(lat), 32'd3);
        check({name, ".stall_cycles"}, 32'(st), 32'd3);
        check({name, ".rdata"}, a_rdata, exp_rdata);
        check({name, ".err"}, 32'(a_err), 32'(exp_err));
        tick;
        check({name, ".rsp_one_cycle"}, 32'(a_rsp_valid), 32'd0);
        check({name, ".idle_ready"}, 32'(a_ready), 32'd1);
        check({name, ".idle_stall"}, 32'(a_stall), 32'd0);
        check({name, ".rdata_hold"}, a_rdata, exp_rdata);
    endtask

    initial begin
        int lat, st, seen;
        a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
        rst_87 = 1'b1;
        tick; tick;
        rst_87 = 1'b0;

        check("rst.ready", 32'(a_ready), 32'd1);
        check("rst.rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("rst.rdata", a_rdata, 32'd0);
        check("rst.err", 32'(a_err), 32'd0);
        check("rst.stall", 32'(a_stall), 32'd0);

        a_access("st10", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
        a_access("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        a_access("st10_be2", 1'b1, 32'h10, 32'h0000_AA00, 4'h2, 32'h0, 1'b0);
        a_access("ld10_b", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);
        a_access("st10_be0", 1'b1, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);
        a_access("ld10_c", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_AAEF, 1'b0);
        a_access("st0", 1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0);
        a_access("ld13_mis", 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
        a_access("ld400_oor", 1'b0, 32'h400, 32'h0, 4'h0, 32'h0, 1'b1);
        a_access("st400_oor", 1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        a_access("ld0", 1'b0, 32'h0, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

        // reset during WAIT drops the load
        a_valid = 1'b1; a_wr = 1'b0; a_addr = 32'h10;
        tick;
        a_valid = 1'b0;
        tick;
        rst_87 = 1'b1;
        tick;
        rst_87 = 1'b0;
        check("midrst.rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("midrst.ready", 32'(a_ready), 32'd1);
        check("midrst.stall", 32'(a_stall), 32'd0);
        check("midrst.rdata", a_rdata, 32'd0);
        check("midrst.err", 32'(a_err), 32'd0);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            seen += int'(a_rsp_valid);
        end
        check("midrst.no_rsp", 32'(seen), 32'd0);

        // store committed at acceptance survives a reset during WAIT
        a_valid = 1'b1; a_wr = 1'b1; a_addr = 32'h8; a_wdata = 32'hCAFE_F00D; a_be = 4'hF;
        tick;
        a_valid = 1'b0;
        rst_87 = 1'b1;
        tick;
        rst_87 = 1'b0;
        a_access("ld8_after_rst", 1'b0, 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // request held valid through WAIT with a changing address
        a_access("st20", 1'b1, 32'h20, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
        a_access("st24", 1'b1, 32'h24, 32'h2222_2222, 4'hF, 32'h0, 1'b0);
        a_valid = 1'b1; a_wr = 1'b0; a_addr = 32'h20;
        tick;
        a_addr = 32'h24;
        check("hold.ready_wait", 32'(a_ready), 32'd0);
        wait_rsp(lat, st);
        check("hold.lat1", 32'(lat), 32'd3);
        check("hold.rdata1", a_rdata, 32'h1111_1111);
        tick;
        check("hold.idle_ready", 32'(a_ready), 32'd1);
        check("hold.idle_stall", 32'(a_stall), 32'd0);
        tick;
        a_valid = 1'b0;
        check("hold.accept2", 32'(a_stall), 32'd1);
        wait_rsp(lat, st);
        check("hold.lat2", 32'(lat), 32'd3);
        check("hold.rdata2", a_rdata, 32'h2222_2222);
        tick;

        // zero wait states, valid held high back to back
        b_valid = 1'b1; b_wr = 1'b1; b_addr = 32'h4; b_wdata = 32'hA5A5_A5A5; b_be = 4'hF;
        tick;
        check("w0.rsp1", 32'(b_rsp_valid), 32'd1);
        check("w0.stall1", 32'(b_stall), 32'd1);
        check("w0.ready1", 32'(b_ready), 32'd0);
        check("w0.err1", 32'(b_err), 32'd0);
        b_wr = 1'b0;
        tick;
        check("w0.gap_rsp", 32'(b_rsp_valid), 32'd0);
        check("w0.gap_stall", 32'(b_stall), 32'd0);
        check("w0.gap_ready", 32'(b_ready), 32'd1);
        tick;
        check("w0.rsp2", 32'(b_rsp_valid), 32'd1);
        check("w0.rdata2", b_rdata, 32'hA5A5_A5A5);
        b_addr = 32'h3;
        tick;
        check("w0.gap2_rsp", 32'(b_rsp_valid), 32'd0);
        tick;
        check("w0.rsp3", 32'(b_rsp_valid), 32'd1);
        check("w0.err3", 32'(b_err), 32'd1);
        check("w0.rdata3", b_rdata, 32'd0);
        b_valid = 1'b0;
        tick;
        check("w0.end_stall", 32'(b_stall), 32'd0);
        tick;
        check("w0.quiet", 32'(b_rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
